register_bank: RTL
==================

REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register and data-port width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register address width; depth SHALL be 2**ADDR_W, 32 registers at default.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have ports rd_addr_a / rd_addr_b, input, ADDR_W bits each: read addresses for ports A and B.
REQ-006 The block SHALL have ports rd_en_a / rd_en_b, input, 1 bit each: read enables for ports A and B.
REQ-007 The block SHALL have ports rd_data_a / rd_data_b, output, DATA_W bits each: registered read data.
REQ-008 The block SHALL have port wr_en, input, 1 bit: write enable.
REQ-009 The block SHALL have port wr_addr, input, ADDR_W bits: write address.
REQ-010 The block SHALL have port wr_data, input, DATA_W bits: write data.
REQ-011 The block SHALL have port dbg_addr, input, ADDR_W bits: debug read address.
REQ-012 The block SHALL have port dbg_data, output, DATA_W bits: combinational debug read of stored contents, with no bypass.

Function
REQ-013 Reads SHALL have 1-cycle latency: with rd_en_x=1 at edge N, rd_data_x SHALL show register[rd_addr_x] after edge N.
REQ-014 With rd_en_x=0, rd_data_x SHALL hold its previous value.
REQ-015 Writes: with wr_en=1 and wr_addr!=0 at edge N, register[wr_addr] SHALL take wr_data at edge N.
REQ-016 Register 0 SHALL be hardwired zero: writes to address 0 discarded; any read of address 0, including dbg, SHALL return all-zero.
REQ-017 Write-read bypass: same-edge wr_en=1, wr_addr==rd_addr_x!=0 and rd_en_x=1 SHALL load wr_data into rd_data_x, not the stale value.
REQ-018 Bypass SHALL apply independently to ports A and B; both may bypass in the same cycle.
REQ-019 A read of address 0 coincident with a write to address 0 SHALL return 0 (no bypass).
REQ-020 A write with wr_en=0 SHALL change no storage, whatever wr_addr and wr_data are.
REQ-021 dbg_data SHALL reflect storage after the most recent edge; a write at edge N SHALL be visible on dbg_data after edge N.
REQ-022 Both read ports may address the same register in the same cycle; both SHALL return identical data.

Reset
REQ-023 While rst=1 at an edge, all registers SHALL clear to 0 and rd_data_a and rd_data_b SHALL clear to 0.
REQ-024 rst SHALL take priority over wr_en and rd_en in the same cycle; the write SHALL be discarded.
REQ-025 Reset asserted mid-sequence SHALL discard all prior contents; after rst deasserts, the first enabled read SHALL return 0 for every address not written since.
REQ-026 No reset is required for correct operation of dbg_data beyond REQ-023; dbg_data SHALL read 0 everywhere after reset.

Verification
REQ-027 Reset then reads: rst 1 cycle, then read A=5, B=31 -> rd_data_a=0, rd_data_b=0 one cycle later.
REQ-028 Write/readback: write R7=0xDEADBEEF; next cycle read A=7 -> rd_data_a=0xDEADBEEF after the following edge; dbg_addr=7 -> 0xDEADBEEF.
REQ-029 R0 protection: write R0=0xFFFFFFFF; read A=0, B=0, dbg_addr=0 -> all read 0x00000000.
REQ-030 Bypass: R3 holds 0x11111111; same cycle write R3=0x22222222 with rd_en_a=1, rd_addr_a=3, rd_en_b=1, rd_addr_b=3 -> both outputs 0x22222222.
REQ-031 Hold and reset priority: rd_en_a=0 with rd_data_a=0x12345678 -> rd_data_a stays 0x12345678; then rst=1 with wr_en=1, R9=0xABCD -> R9 reads 0, rd_data_a=0.

Source files
------------

// File: rtl/register_bank.sv
// -----------------------------------------------------------------------------
// register_bank
//   Multi-ported register file: two registered read ports (A, B), one write
//   port and one combinational debug read port. Register 0 is hardwired to
//   zero. A read that addresses the register being written on the same edge
//   returns the new write data (write-read bypass), independently per port.
//
// Parameters
//   DATA_W   register and data-port width in bits
//   ADDR_W   register address width; depth = 2**ADDR_W
//
// Ports
//   clk                    single clock, all state updates on rising edge
//   rst                    synchronous, active-high reset (clears all state)
//   rd_addr_a / rd_addr_b  read addresses for ports A and B
//   rd_en_a   / rd_en_b    read enables; when low the read data holds
//   rd_data_a / rd_data_b  registered read data (1-cycle latency)
//   wr_en, wr_addr, wr_data  write port (writes to address 0 discarded)
//   dbg_addr, dbg_data     combinational debug read of storage, no bypass
// -----------------------------------------------------------------------------
module register_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic              rd_en_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              rd_en_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  logic              wr_live;
  logic [DATA_W-1:0] next_a;
  logic [DATA_W-1:0] next_b;

  // A write to address 0 is discarded, so it never counts as live and can
  // never be bypassed onto a read port.
  assign wr_live = wr_en && (wr_addr != '0);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
    next_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];
    if (wr_live && (wr_addr == rd_addr_a)) next_a = wr_data;
    if (wr_live && (wr_addr == rd_addr_b)) next_b = wr_data;
  end

  // Debug port shows stored contents only; address 0 always reads zero even
  // though its storage location is never written.
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage array is reset here on purpose: contents must read
      // zero after reset, which forces flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      if (wr_live) begin
        regs[wr_addr] <= wr_data;
      end
      if (rd_en_a) begin
        rd_data_a <= next_a;
      end
      if (rd_en_b) begin
        rd_data_b <= next_b;
      end
    end
  end

endmodule
